uart_host_loader: RTL and testbench
===================================

# uart_host_loader

Host-side end of the load/execute/readback UART protocol used by the multicore processor top level. On `start` it streams an instruction image and then a data image out as UART bytes, then collects the returned result words from the UART receiver into a local result RAM. It sits between two source ROMs, one result RAM and the `uart_system` byte transmitter/receiver. It runs as an in-system host for board-to-board tests and as a synthesizable stimulus driver for the processor top.

## Interface
Parameters:
- `WORD_WIDTH`, 36: data-image and result word width.
- `INS_WIDTH`, 8: instruction word width.
- `INS_COUNT`, 256: instruction words sent.
- `DATA_COUNT`, 16: data words sent.
- `ADDR_WIDTH`, 12: address width for the ROMs and the result RAM.
- `UART_WIDTH`, 8: byte width.
- `TIMEOUT_CYCLES`, 50_000_000: receive watchdog limit. Used only with the macro.

Ports:
- `clk` in 1: clock.
- `rstN` in 1: reset. Synchronous, active-low.
- `start` in 1: begin a run. Sampled only in IDLE, DONE or TIMEOUT.
- `rx_start_addr`, `rx_end_addr` in ADDR_WIDTH: result window. Captured when `start` is accepted.
- `ins_rd_addr` out ADDR_WIDTH; `ins_rd_data` in INS_WIDTH: instruction ROM, 1-cycle read latency.
- `data_rd_addr` out ADDR_WIDTH; `data_rd_data` in WORD_WIDTH: data ROM, 1-cycle read latency.
- `res_wr_en` out 1; `res_wr_addr` out ADDR_WIDTH; `res_wr_data` out WORD_WIDTH: result RAM write port.
- `tx_byte_start` out 1; `byte_for_tx` out UART_WIDTH; `tx_ready` in 1: transmitter handshake.
- `rx_new_byte` in 1; `byte_from_rx` in UART_WIDTH: receiver byte pulse and byte.
- `busy` out 1; `done` out 1; `error` out 1: run status.

## Operation
- Bytes per word: BPW = ceil(width/UART_WIDTH). This gives 1 for instructions and 5 for data.
- Bytes go out least-significant first. Unused upper bits of the last byte are sent as zero.
- States: IDLE, FETCH, MEM_WAIT, SEND, RECV, DONE, and TIMEOUT (macro only).
- A stream-select register chooses INS or DATA. A word index and a byte index count progress.
- IDLE: on `start`=1, capture the result window, set stream to INS, clear the index → FETCH.
- FETCH: drive the selected ROM address equal to the index → MEM_WAIT.
- MEM_WAIT: latch the ROM word into the shift register, clear the byte index → SEND.
- SEND: once `tx_ready`=1, pulse `tx_byte_start` for one cycle with the low byte, then shift the word right by UART_WIDTH. After BPW bytes:
  - Next word if one remains → FETCH.
  - Otherwise INS → switch to DATA, index=0 → FETCH.
  - Otherwise DATA → RECV.
- RECV:
  - Each `rx_new_byte` pulse shifts the byte in from the top, giving little-endian assembly.
  - After BPW bytes, pulse `res_wr_en` for one cycle at the current result address, then increment the address.
  - The write at `rx_end_addr` → DONE.
- Result count = (rx_end_addr − rx_start_addr + 1) mod 2^ADDR_WIDTH. The address wraps at 2^ADDR_WIDTH. start==end means one word.
- `rx_new_byte` outside RECV is ignored and does not pre-fill the assembler.
- DONE: `done`=1 and holds. A new `start` restarts the run exactly as from IDLE.
- `start` in any other state is ignored.
- `busy`=1 in FETCH, MEM_WAIT, SEND and RECV.
- INS_COUNT or DATA_COUNT = 0: that stream is skipped entirely.

## Timing
- Reset value of every output is 0, state is IDLE, and all counters are 0. Reset mid-run aborts at once with no further strobes.
- `start` accepted at edge N: FETCH in cycle N+1, MEM_WAIT in N+2, first `tx_byte_start` in N+3 at the earliest (`tx_ready` high).
- The transmitter drops `tx_ready` by the cycle after `tx_byte_start`. The block ignores `tx_ready` for exactly one cycle after each pulse.
- `res_wr_en` is asserted the cycle after the final `rx_new_byte` of a word, with address and data valid in that same cycle.
- `done` rises the cycle after the last `res_wr_en`.
- A byte arriving in the same cycle as the last-word write is accepted and ignored (state is DONE).

## Configuration
- `HOST_LOADER_TIMEOUT_EN` defined:
  - A watchdog counts cycles in RECV and clears on every `rx_new_byte`.
  - At TIMEOUT_CYCLES → TIMEOUT: `error`=1, `busy`=0, `done`=0. These hold until reset or `start`.
- Macro undefined: no counter, no TIMEOUT state, `error` tied to 0, and RECV waits indefinitely.

## Structure
- Package `host_loader_pkg`: the state enum `host_state_t`, the stream enum `stream_t`, and the `bytes_per_word(width, uart_width)` constant function.
- Natural sub-module: `uart_word_assembler`. It covers the RECV byte-to-word shift, the byte count and the write strobe. The top FSM keeps transmit, sequencing and status.

## Test plan
- INS_COUNT=2 ({0xA1,0xB2}), DATA_COUNT=1 (0x9_8765_4321), window 5..5, `tx_ready` model 10-cycle busy → expect:
  - Bytes A1, B2, 21, 43, 65, 87, 09 in order.
  - Then RX bytes EF,CD,AB,89,07 → `res_wr_en` at addr 5 with data 0x7_89AB_CDEF.
  - `done`=1.
- `tx_ready` held low 100 cycles mid-stream → no `tx_byte_start` during the stall. The next byte follows within 1 cycle of `tx_ready` rising, with no duplicate or skipped byte.
- Window start=0xFFF, end=0x001 → three writes at 0xFFF, 0x000, 0x001, then `done`.
- `rx_new_byte` pulses during SEND → no writes. Result data is formed only from bytes received in RECV.
- Reset asserted during SEND byte 3 → all outputs 0 next cycle. A new `start` resends from instruction word 0.
- With `HOST_LOADER_TIMEOUT_EN` and TIMEOUT_CYCLES=100, no RX bytes → `error`=1 exactly 100 cycles after RECV entry, `busy`=0. Without the macro → `busy` stays 1 and `error` stays 0.

Source files
------------

// File: rtl/host_loader_pkg.sv
// Shared types and sizing helper for the UART host loader.
// The TIMEOUT state only exists when HOST_LOADER_TIMEOUT_EN is defined.
package host_loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    MEM_WAIT = 3'd2,
    SEND     = 3'd3,
    RECV     = 3'd4,
    DONE     = 3'd5
`ifdef HOST_LOADER_TIMEOUT_EN
    ,
    TIMEOUT  = 3'd6
`endif
  } host_state_t;

  typedef enum logic {
    STREAM_INS  = 1'b0,
    STREAM_DATA = 1'b1
  } stream_t;

  // Number of UART bytes needed to carry one word, rounded up.
  function automatic int bytes_per_word(input int width, input int uartWidth);
    return (width + uartWidth - 1) / uartWidth;
  endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Receive-side word builder: shifts UART bytes in from the top (little-endian)
// and pulses wordValid the cycle after the last byte of each word.
module uart_word_assembler #(
  parameter int UART_WIDTH = 8,
  parameter int WORD_WIDTH = 36,
  parameter int BPW        = 5
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  enable,
  input  logic                  newByte,
  input  logic [UART_WIDTH-1:0] byteIn,
  output logic                  wordValid,
  output logic [WORD_WIDTH-1:0] word
);

  localparam int ASM_W = BPW * UART_WIDTH;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [ASM_W-1:0] asmReg;
  logic [ASM_W-1:0] shifted;
  logic [CNT_W-1:0] byteCnt;
  logic             lastByte;

  if (BPW > 1) begin : gShift
    assign shifted = {byteIn, asmReg[ASM_W-1:UART_WIDTH]};
  end else begin : gNoShift
    assign shifted = byteIn;
  end

  assign lastByte = (byteCnt == CNT_W'(BPW - 1));

  // Leaving RECV wipes the partial word so stray bytes never pre-fill it.
  always_ff @(posedge clk) begin
    if (!rstN || !enable) begin
      asmReg    <= '0;
      byteCnt   <= '0;
      wordValid <= 1'b0;
    end else begin
      wordValid <= newByte && lastByte;
      if (newByte) begin
        asmReg  <= shifted;
        byteCnt <= lastByte ? '0 : byteCnt + 1'b1;
      end
    end
  end

  assign word = asmReg[WORD_WIDTH-1:0];

  if (ASM_W > WORD_WIDTH) begin : gPadBits
    logic unusedPadBits;
    assign unusedPadBits = ^asmReg[ASM_W-1:WORD_WIDTH];
  end

endmodule

// File: rtl/uart_host_loader.sv
// Host side of the load/execute/readback UART protocol: streams the instruction
// and data images out, then collects result words. Optional watchdog: HOST_LOADER_TIMEOUT_EN.
module uart_host_loader
  import host_loader_pkg::*;
#(
  parameter int WORD_WIDTH     = 36,
  parameter int INS_WIDTH      = 8,
  parameter int INS_COUNT      = 256,
  parameter int DATA_COUNT     = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int UART_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] rx_start_addr,
  input  logic [ADDR_WIDTH-1:0] rx_end_addr,
  output logic [ADDR_WIDTH-1:0] ins_rd_addr,
  input  logic [INS_WIDTH-1:0]  ins_rd_data,
  output logic [ADDR_WIDTH-1:0] data_rd_addr,
  input  logic [WORD_WIDTH-1:0] data_rd_data,
  output logic                  res_wr_en,
  output logic [ADDR_WIDTH-1:0] res_wr_addr,
  output logic [WORD_WIDTH-1:0] res_wr_data,
  output logic                  tx_byte_start,
  output logic [UART_WIDTH-1:0] byte_for_tx,
  input  logic                  tx_ready,
  input  logic                  rx_new_byte,
  input  logic [UART_WIDTH-1:0] byte_from_rx,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BPW_INS  = bytes_per_word(INS_WIDTH, UART_WIDTH);
  localparam int BPW_DATA = bytes_per_word(WORD_WIDTH, UART_WIDTH);
  localparam int BPW_MAX  = (BPW_INS > BPW_DATA) ? BPW_INS : BPW_DATA;
  localparam int SHIFT_W  = BPW_MAX * UART_WIDTH;
  localparam int BIDX_W   = $clog2(BPW_MAX + 1);

  // Empty streams are skipped straight from the start decision.
  localparam host_state_t FIRST_STATE  = (INS_COUNT > 0 || DATA_COUNT > 0) ? FETCH : RECV;
  localparam stream_t     FIRST_STREAM = (INS_COUNT > 0) ? STREAM_INS : STREAM_DATA;

  host_state_t           state;
  host_state_t           nextState;
  stream_t               stream;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [BIDX_W-1:0]     byteIdx;
  logic [SHIFT_W-1:0]    shiftReg;
  logic [SHIFT_W-1:0]    insExt;
  logic [SHIFT_W-1:0]    dataExt;
  logic                  txHold;
  logic [ADDR_WIDTH-1:0] resAddr;
  logic [ADDR_WIDTH-1:0] endAddr;

  logic                  restartable;
  logic                  startAccept;
  logic                  txFire;
  logic                  lastByte;
  logic                  lastWord;
  logic                  asmValid;
  logic [WORD_WIDTH-1:0] asmWord;
  logic                  wrStrobe;
  logic                  recvLast;
  int                    curBpw;
  int                    curCount;

  assign insExt  = SHIFT_W'(ins_rd_data);
  assign dataExt = SHIFT_W'(data_rd_data);

  always_comb begin
    restartable = (state == IDLE) || (state == DONE);
`ifdef HOST_LOADER_TIMEOUT_EN
    if (state == TIMEOUT) restartable = 1'b1;
`endif
  end

  assign startAccept = start && restartable;
  assign curBpw      = (stream == STREAM_INS) ? BPW_INS : BPW_DATA;
  assign curCount    = (stream == STREAM_INS) ? INS_COUNT : DATA_COUNT;
  assign lastByte    = (int'(byteIdx) == curBpw - 1);
  assign lastWord    = (int'(wordIdx) == curCount - 1);

  // txHold masks tx_ready for the cycle after a pulse, covering a transmitter
  // that only drops its ready flag one cycle late.
  assign txFire   = rstN && (state == SEND) && tx_ready && !txHold;
  assign wrStrobe = rstN && (state == RECV) && asmValid;
  assign recvLast = wrStrobe && (resAddr == endAddr);

  uart_word_assembler #(
    .UART_WIDTH (UART_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .BPW        (BPW_DATA)
  ) uAssembler (
    .clk       (clk),
    .rstN      (rstN),
    .enable    (state == RECV),
    .newByte   (rx_new_byte),
    .byteIn    (byte_from_rx),
    .wordValid (asmValid),
    .word      (asmWord)
  );

`ifdef HOST_LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdCnt;
  logic            wdExpired;

  // Watchdog measures silence on the receive side only.
  always_ff @(posedge clk) begin
    if (!rstN || state != RECV || rx_new_byte) begin
      wdCnt <= '0;
    end else begin
      wdCnt <= wdCnt + 1'b1;
    end
  end

  assign wdExpired = (state == RECV) && !rx_new_byte && (wdCnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (start) nextState = FIRST_STATE;
      end
      FETCH:    nextState = MEM_WAIT;
      MEM_WAIT: nextState = SEND;
      SEND: begin
        if (txFire && lastByte) begin
          if (!lastWord) begin
            nextState = FETCH;
          end else if (stream == STREAM_INS && DATA_COUNT > 0) begin
            nextState = FETCH;
          end else begin
            nextState = RECV;
          end
        end
      end
      RECV: begin
        if (recvLast) begin
          nextState = DONE;
        end
`ifdef HOST_LOADER_TIMEOUT_EN
        else if (wdExpired) begin
          nextState = TIMEOUT;
        end
`endif
      end
`ifdef HOST_LOADER_TIMEOUT_EN
      TIMEOUT: begin
        if (start) nextState = FIRST_STATE;
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  // Sequencing datapath: stream select, word/byte indices, shift register, result address.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      stream   <= STREAM_INS;
      wordIdx  <= '0;
      byteIdx  <= '0;
      shiftReg <= '0;
      txHold   <= 1'b0;
      resAddr  <= '0;
      endAddr  <= '0;
    end else begin
      txHold <= txFire;
      if (startAccept) begin
        stream  <= FIRST_STREAM;
        wordIdx <= '0;
        byteIdx <= '0;
        resAddr <= rx_start_addr;
        endAddr <= rx_end_addr;
      end
      case (state)
        MEM_WAIT: begin
          shiftReg <= (stream == STREAM_INS) ? insExt : dataExt;
          byteIdx  <= '0;
        end
        SEND: begin
          if (txFire) begin
            shiftReg <= shiftReg >> UART_WIDTH;
            byteIdx  <= byteIdx + 1'b1;
            if (lastByte) begin
              if (!lastWord) begin
                wordIdx <= wordIdx + 1'b1;
              end else begin
                stream  <= STREAM_DATA;
                wordIdx <= '0;
              end
            end
          end
        end
        RECV: begin
          if (wrStrobe) resAddr <= resAddr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    tx_byte_start = 1'b0;
    byte_for_tx   = '0;
    res_wr_en     = 1'b0;
    ins_rd_addr   = '0;
    data_rd_addr  = '0;
    case (state)
      FETCH, MEM_WAIT: busy = 1'b1;
      SEND: begin
        busy          = 1'b1;
        tx_byte_start = txFire;
        byte_for_tx   = shiftReg[UART_WIDTH-1:0];
      end
      RECV: begin
        busy      = 1'b1;
        res_wr_en = wrStrobe;
      end
      DONE: done = 1'b1;
`ifdef HOST_LOADER_TIMEOUT_EN
      TIMEOUT: error = 1'b1;
`endif
      default: ;
    endcase
    if (stream == STREAM_INS) begin
      ins_rd_addr = wordIdx;
    end else begin
      data_rd_addr = wordIdx;
    end
  end

  assign res_wr_addr = resAddr;
  assign res_wr_data = asmWord;

endmodule

// File: tb/tb_uart_host_loader.sv
// Directed bench for uart_host_loader: two instruction words, one data word,
// a 10-cycle-busy transmitter model and hand-computed result words.
module tb_uart_host_loader;

  localparam int AW = 12;
  localparam int WW = 36;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic [AW-1:0] rxStartAddr;
  logic [AW-1:0] rxEndAddr;
  logic [AW-1:0] insRdAddr;
  logic [7:0]    insRdData;
  logic [AW-1:0] dataRdAddr;
  logic [WW-1:0] dataRdData;
  logic          resWrEn;
  logic [AW-1:0] resWrAddr;
  logic [WW-1:0] resWrData;
  logic          txByteStart;
  logic [7:0]    byteForTx;
  logic          txReady;
  logic          rxNewByte;
  logic [7:0]    byteFromRx;
  logic          busy;
  logic          done;
  logic          error;

  logic          txReadyInt = 1'b1;
  logic          stall;
  int            txBusyCnt;
  logic [7:0]    txLog[$];
  logic [AW-1:0] wrAddrLog[$];
  logic [WW-1:0] wrDataLog[$];
  logic [7:0]    expBytes[7];

  int            errors = 0;
  int            checks = 0;
  int            hits;

  always #5 clk = ~clk;

  uart_host_loader #(
    .WORD_WIDTH     (WW),
    .INS_WIDTH      (8),
    .INS_COUNT      (2),
    .DATA_COUNT     (1),
    .ADDR_WIDTH     (AW),
    .UART_WIDTH     (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .start         (start),
    .rx_start_addr (rxStartAddr),
    .rx_end_addr   (rxEndAddr),
    .ins_rd_addr   (insRdAddr),
    .ins_rd_data   (insRdData),
    .data_rd_addr  (dataRdAddr),
    .data_rd_data  (dataRdData),
    .res_wr_en     (resWrEn),
    .res_wr_addr   (resWrAddr),
    .res_wr_data   (resWrData),
    .tx_byte_start (txByteStart),
    .byte_for_tx   (byteForTx),
    .tx_ready      (txReady),
    .rx_new_byte   (rxNewByte),
    .byte_from_rx  (byteFromRx),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  // Source ROMs with one cycle of read latency.
  always @(posedge clk) begin
    insRdData  <= (insRdAddr == 12'd0) ? 8'hA1 : (insRdAddr == 12'd1) ? 8'hB2 : 8'h00;
    dataRdData <= (dataRdAddr == 12'd0) ? 36'h9_8765_4321 : 36'h0;
  end

  // Transmitter: busy for 10 cycles after each accepted byte.
  always @(posedge clk) begin
    if (!rstN) begin
      txBusyCnt  <= 0;
      txReadyInt <= 1'b1;
    end else if (txByteStart) begin
      txLog.push_back(byteForTx);
      txBusyCnt  <= 10;
      txReadyInt <= 1'b0;
    end else if (txBusyCnt > 1) begin
      txBusyCnt <= txBusyCnt - 1;
    end else begin
      txBusyCnt  <= 0;
      txReadyInt <= 1'b1;
    end
  end

  assign txReady = txReadyInt && !stall;

  always @(posedge clk) begin
    if (rstN && resWrEn) begin
      wrAddrLog.push_back(resWrAddr);
      wrDataLog.push_back(resWrData);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rxNewByte  = 1'b1;
    byteFromRx = b;
    @(negedge clk);
    rxNewByte  = 1'b0;
  endtask

  task automatic sendRxWord(input logic [35:0] w);
    logic [39:0] ext;
    ext = {4'h0, w};
    for (int i = 0; i < 5; i++) applyStimulus(ext[8*i +: 8]);
  endtask

  task automatic startRun(input logic [AW-1:0] s, input logic [AW-1:0] e);
    @(negedge clk);
    rxStartAddr = s;
    rxEndAddr   = e;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic waitTx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && txLog.size() < n; i++) @(negedge clk);
    checkOutput(tag, txLog.size(), n);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".busy"}, busy, 1'b0);
    checkOutput({tag, ".done"}, done, 1'b0);
    checkOutput({tag, ".error"}, error, 1'b0);
    checkOutput({tag, ".txStart"}, txByteStart, 1'b0);
    checkOutput({tag, ".txByte"}, byteForTx, 8'h00);
    checkOutput({tag, ".wrEn"}, resWrEn, 1'b0);
    checkOutput({tag, ".wrAddr"}, resWrAddr, 12'h000);
    checkOutput({tag, ".wrData"}, resWrData, 36'h0);
    checkOutput({tag, ".insAddr"}, insRdAddr, 12'h000);
    checkOutput({tag, ".dataAddr"}, dataRdAddr, 12'h000);
  endtask

  task automatic checkTxBytes(input string tag);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("%s.byte%0d", tag, i), (i < txLog.size()) ? txLog[i] : 8'hxx, expBytes[i]);
    end
  endtask

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expBytes    = '{8'hA1, 8'hB2, 8'h21, 8'h43, 8'h65, 8'h87, 8'h09};
    rstN        = 1'b0;
    start       = 1'b0;
    stall       = 1'b0;
    rxNewByte   = 1'b0;
    byteFromRx  = 8'h00;
    rxStartAddr = '0;
    rxEndAddr   = '0;

    repeat (3) @(negedge clk);
    checkQuiet("reset");
    rstN = 1'b1;

    // Run 1: window 5..5, stray RX bytes during SEND, exact start latency.
    $display("[TB] run 1: basic load and single result word");
    startRun(12'd5, 12'd5);
    checkOutput("r1.fetchBusy", busy, 1'b1);
    checkOutput("r1.fetchInsAddr", insRdAddr, 12'd0);
    checkOutput("r1.fetchTx", txByteStart, 1'b0);
    @(negedge clk);
    checkOutput("r1.memWaitTx", txByteStart, 1'b0);
    @(negedge clk);
    checkOutput("r1.firstTx", txByteStart, 1'b1);
    checkOutput("r1.firstByte", byteForTx, 8'hA1);
    repeat (3) applyStimulus(8'h55);
    waitTx("r1.txCount", 7, 300);
    checkTxBytes("r1");
    checkOutput("r1.noEarlyWrites", wrAddrLog.size(), 0);
    checkOutput("r1.recvBusy", busy, 1'b1);
    sendRxWord(36'h7_89AB_CDEF);
    checkOutput("r1.wrEn", resWrEn, 1'b1);
    checkOutput("r1.wrAddr", resWrAddr, 12'd5);
    checkOutput("r1.wrData", resWrData, 36'h7_89AB_CDEF);
    @(negedge clk);
    checkOutput("r1.done", done, 1'b1);
    checkOutput("r1.idleBusy", busy, 1'b0);
    checkOutput("r1.wrCount", wrAddrLog.size(), 1);
    repeat (5) @(negedge clk);
    checkOutput("r1.doneHolds", done, 1'b1);

    // Run 2: restart from DONE, 100-cycle transmitter stall, wrapping window.
    $display("[TB] run 2: stall and wrapping result window");
    txLog.delete();
    wrAddrLog.delete();
    wrDataLog.delete();
    startRun(12'hFFF, 12'h001);
    waitTx("r2.txFirst", 1, 10);
    stall = 1'b1;
    hits  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txByteStart !== 1'b0) hits++;
    end
    checkOutput("r2.stallPulses", hits, 0);
    checkOutput("r2.stallCount", txLog.size(), 1);
    stall = 1'b0;
    waitTx("r2.afterStall", 2, 2);
    waitTx("r2.txCount", 7, 300);
    checkTxBytes("r2");
    sendRxWord(36'h1_2345_6789);
    sendRxWord(36'hF_EDCB_A987);
    sendRxWord(36'h0_0000_0055);
    @(negedge clk);
    checkOutput("r2.done", done, 1'b1);
    checkOutput("r2.wrCount", wrAddrLog.size(), 3);
    checkOutput("r2.wrAddr0", (wrAddrLog.size() > 0) ? wrAddrLog[0] : 12'hxxx, 12'hFFF);
    checkOutput("r2.wrAddr1", (wrAddrLog.size() > 1) ? wrAddrLog[1] : 12'hxxx, 12'h000);
    checkOutput("r2.wrAddr2", (wrAddrLog.size() > 2) ? wrAddrLog[2] : 12'hxxx, 12'h001);
    checkOutput("r2.wrData0", (wrDataLog.size() > 0) ? wrDataLog[0] : 36'hx, 36'h1_2345_6789);
    checkOutput("r2.wrData1", (wrDataLog.size() > 1) ? wrDataLog[1] : 36'hx, 36'hF_EDCB_A987);
    checkOutput("r2.wrData2", (wrDataLog.size() > 2) ? wrDataLog[2] : 36'hx, 36'h0_0000_0055);

    // Run 3: reset while SEND waits for byte 3, then a clean resend.
    $display("[TB] run 3: reset mid-send then restart");
    txLog.delete();
    startRun(12'd0, 12'd0);
    waitTx("r3.txTwo", 2, 100);
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkQuiet("midReset");
    checkOutput("r3.noTxInReset", txLog.size(), 2);
    rstN = 1'b1;
    txLog.delete();
    startRun(12'd0, 12'd0);
    waitTx("r3.txCount", 7, 300);
    checkTxBytes("r3");

    // Now in the first RECV cycle; no bytes will arrive.
    hits = 0;
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (error !== 1'b0 || busy !== 1'b1) hits++;
    end
    checkOutput("r3.earlyTimeout", hits, 0);
    @(negedge clk);
`ifdef HOST_LOADER_TIMEOUT_EN
    checkOutput("r3.toError", error, 1'b1);
    checkOutput("r3.toBusy", busy, 1'b0);
    checkOutput("r3.toDone", done, 1'b0);
`else
    checkOutput("r3.waitError", error, 1'b0);
    checkOutput("r3.waitBusy", busy, 1'b1);
    repeat (50) @(negedge clk);
    checkOutput("r3.stillWaiting", busy, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
